sync_fifo_flags: RTL

Single-clock, parametrised FIFO with registered status flags, occupancy count, programmable almost-full/almost-empty thresholds and single-cycle overflow/underflow error pulses. It is the single-clock successor to the team's dual-clock FIFO, for buffering between blocks in one clock domain. Unlike that block, it accepts a write on a full FIFO when a read happens in the same cycle, and it reports exact occupancy.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem_sdp.sv | 27 ++
 rtl/sync_fifo_flags.sv | 100 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers: pointer width from depth and the occupancy-count width.
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int unsigned count_width(input int unsigned depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_mem_sdp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Read-before-write: a same-address read returns the old word (full FIFO, read+write).
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered count, full/empty, programmable almost flags and error pulses.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int PTR_WIDTH     = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int CNT_W = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, empty_q, afull_q, aempty_q;
  logic                 rvalid_q, ovf_q, udf_q;
  logic                 rd_seen_q;
  logic                 wr_acc, rd_acc;
  logic [WIDTH-1:0]     mem_rdata;

  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    wr_acc   = wr_en & (~full_q | rd_en);
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(rd_acc);
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  // Flags are registered from the next count so they always agree with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      rvalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= (count_d == CNT_W'(DEPTH));
      empty_q   <= (count_d == '0);
      afull_q   <= (count_d >= CNT_W'(AFULL_THRESH));
      aempty_q  <= (count_d <= CNT_W'(AEMPTY_THRESH));
      rvalid_q  <= rd_acc;
      ovf_q     <= wr_en & full_q & ~rd_en;
      udf_q     <= rd_en & empty_q;
      if (rd_acc) rd_seen_q <= 1'b1;
    end
  end

  fifo_mem_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  // Storage read register has no reset; rdata reads as zero until the first read after reset.
  assign rdata        = rd_seen_q ? mem_rdata : '0;
  assign rvalid       = rvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
